// File: rtl/sample_ring_ctrl.sv
// Circular sample store between the mixer pipeline and the DAC / Avalon-ST outputs, with a priming FSM.
// Define SAMPLE_RING_STATS_EN to implement the underrun/overflow/stream-drop counters; otherwise they read 0.
module sample_ring_ctrl #(
  parameter int DEPTH     = 128,
  parameter int DW        = 24,
  parameter int HEADROOM  = 4,
  parameter int PRIME_LVL = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_tick,
  input  logic [DW-1:0]                i_sample,
  input  logic                         i_sample_vld,
  output logic                         o_gen_en,
  output logic [DW-1:0]                o_dac_sample,
  output logic [31:0]                  aso_data,
  output logic                         aso_valid,
  input  logic                         aso_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic                         o_running,
  output logic [15:0]                  o_underrun_cnt,
  output logic [15:0]                  o_overflow_cnt,
  output logic [15:0]                  o_st_drop_cnt
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL    = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_C     = LW'(PRIME_LVL);
  localparam logic [LW-1:0] GEN_MAX_LVL = LW'(DEPTH - HEADROOM - 1);
  localparam logic [PW-1:0] LAST_SLOT   = PW'(DEPTH - 1);

  typedef enum logic {PRIME, RUN} state_t;

  state_t          state;
  logic [DW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   count, count_nxt;
  logic            push, pop, underrun;
  logic [DW-1:0]   rd_data;

  // Full/empty decisions look only at the pre-edge count.
  assign push      = i_sample_vld && (count < FULL_LVL);
  assign pop       = (state == RUN) && i_tick && (count != '0);
  assign underrun  = (state == RUN) && i_tick && (count == '0);
  assign count_nxt = count + LW'(push) - LW'(pop);
  assign rd_data   = mem[rd_ptr];
  assign o_level   = count;
  assign o_running = (state == RUN);

  // NOTE: the sample array has no reset; its contents are meaningless until written, and leaving it
  // out of the reset tree lets it map onto plain storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_sample;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= PRIME;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      o_gen_en     <= 1'b1;
      o_dac_sample <= '0;
      aso_data     <= '0;
      aso_valid    <= 1'b0;
    end else begin
      count    <= count_nxt;
      o_gen_en <= (count_nxt <= GEN_MAX_LVL);
      if (push) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PW'(1);

      case (state)
        PRIME: if (count >= PRIME_C) state <= RUN;
        RUN:   if (underrun) state <= PRIME;
        default: state <= PRIME;
      endcase

      if (pop) begin
        rd_ptr       <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + PW'(1);
        o_dac_sample <= rd_data;
        aso_data     <= 32'(signed'(rd_data));
        aso_valid    <= 1'b1;
      end else if (aso_valid && aso_ready) begin
        aso_valid <= 1'b0;
      end
    end
  end

`ifdef SAMPLE_RING_STATS_EN
  logic overflow, st_drop;
  logic [15:0] underrun_q, overflow_q, st_drop_q;

  assign overflow = i_sample_vld && (count == FULL_LVL);
  // A pop landing on an unaccepted beat replaces it; that lost beat is what gets counted.
  assign st_drop  = pop && aso_valid && !aso_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_q <= '0;
      overflow_q <= '0;
      st_drop_q  <= '0;
    end else begin
      if (underrun && underrun_q != 16'hFFFF) underrun_q <= underrun_q + 16'd1;
      if (overflow && overflow_q != 16'hFFFF) overflow_q <= overflow_q + 16'd1;
      if (st_drop  && st_drop_q  != 16'hFFFF) st_drop_q  <= st_drop_q + 16'd1;
    end
  end

  assign o_underrun_cnt = underrun_q;
  assign o_overflow_cnt = overflow_q;
  assign o_st_drop_cnt  = st_drop_q;
`else
  assign o_underrun_cnt = '0;
  assign o_overflow_cnt = '0;
  assign o_st_drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_sample_ring_ctrl.sv
// Directed bench for sample_ring_ctrl at DEPTH=128, DW=24, HEADROOM=4, PRIME_LVL=64.
// Counter expectations follow SAMPLE_RING_STATS_EN, matching the build of the design.
module tb_sample_ring_ctrl;

`ifdef SAMPLE_RING_STATS_EN
  localparam logic [31:0] ONE_IF_STATS = 32'd1;
`else
  localparam logic [31:0] ONE_IF_STATS = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_tick;
  logic [23:0] i_sample;
  logic        i_sample_vld;
  logic        o_gen_en;
  logic [23:0] o_dac_sample;
  logic [31:0] aso_data;
  logic        aso_valid;
  logic        aso_ready;
  logic [7:0]  o_level;
  logic        o_running;
  logic [15:0] o_underrun_cnt;
  logic [15:0] o_overflow_cnt;
  logic [15:0] o_st_drop_cnt;

  int vectors = 0;
  int misses  = 0;

  sample_ring_ctrl #(.DEPTH(128), .DW(24), .HEADROOM(4), .PRIME_LVL(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_tick         (i_tick),
    .i_sample       (i_sample),
    .i_sample_vld   (i_sample_vld),
    .o_gen_en       (o_gen_en),
    .o_dac_sample   (o_dac_sample),
    .aso_data       (aso_data),
    .aso_valid      (aso_valid),
    .aso_ready      (aso_ready),
    .o_level        (o_level),
    .o_running      (o_running),
    .o_underrun_cnt (o_underrun_cnt),
    .o_overflow_cnt (o_overflow_cnt),
    .o_st_drop_cnt  (o_st_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      misses++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one edge; inputs set before the call apply at that edge, outputs are read 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [23:0] v);
    i_sample = v; i_sample_vld = 1'b1;
    step();
    i_sample_vld = 1'b0;
  endtask

  task automatic tick();
    i_tick = 1'b1;
    step();
    i_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_tick = 1'b0; i_sample = '0; i_sample_vld = 1'b0; aso_ready = 1'b1;
    #2;
    check("rst_gen_en",   32'(o_gen_en), 32'd1);
    check("rst_level",    32'(o_level), 32'd0);
    check("rst_running",  32'(o_running), 32'd0);
    check("rst_valid",    32'(aso_valid), 32'd0);
    check("rst_dac",      32'(o_dac_sample), 32'd0);
    check("rst_aso_data", aso_data, 32'd0);
    check("rst_cnts",     {o_underrun_cnt, o_overflow_cnt | o_st_drop_cnt}, 32'd0);
    #10 reset = 1'b0;

    // Prime: 63 samples are not enough to start.
    for (int v = 1; v <= 63; v++) push(24'(v));
    for (int t = 0; t < 5; t++) begin
      tick();
      check("prime_valid", 32'(aso_valid), 32'd0);
    end
    check("prime_running", 32'(o_running), 32'd0);
    check("prime_dac",     32'(o_dac_sample), 32'd0);
    check("prime_level",   32'(o_level), 32'd63);
    push(24'd64);
    check("prime_lvl64_still", 32'(o_running), 32'd0);
    step();
    check("prime_to_run", 32'(o_running), 32'd1);
    tick();
    check("first_pop_dac",  32'(o_dac_sample), 32'd1);
    check("first_pop_data", aso_data, 32'd1);
    check("first_pop_vld",  32'(aso_valid), 32'd1);
    check("first_pop_lvl",  32'(o_level), 32'd63);
    step();
    check("accept_clears", 32'(aso_valid), 32'd0);

    // Throttle: fill to 123, then 124 drops gen_en, 4 more reach full, then one is dropped.
    for (int v = 65; v <= 124; v++) push(24'(v));
    check("lvl123",     32'(o_level), 32'd123);
    check("gen_en_123", 32'(o_gen_en), 32'd1);
    push(24'd125);
    check("lvl124",     32'(o_level), 32'd124);
    check("gen_en_124", 32'(o_gen_en), 32'd0);
    for (int v = 126; v <= 129; v++) push(24'(v));
    check("lvl_full", 32'(o_level), 32'd128);
    push(24'h0003E7);
    check("full_drop_lvl", 32'(o_level), 32'd128);
    check("overflow_cnt",  32'(o_overflow_cnt), ONE_IF_STATS);
    check("gen_en_full",   32'(o_gen_en), 32'd0);

    // Drain 127 samples back-to-back; order must hold across the pointer wrap.
    for (int k = 0; k < 127; k++) begin
      tick();
      check("drain_order", 32'(o_dac_sample), 32'(k + 2));
    end
    check("drain_lvl1", 32'(o_level), 32'd1);
    check("drain_gen_en", 32'(o_gen_en), 32'd1);

    // Simultaneous push and pop at level 1.
    i_sample = 24'd200; i_sample_vld = 1'b1; i_tick = 1'b1;
    step();
    i_sample_vld = 1'b0; i_tick = 1'b0;
    check("simul_lvl",  32'(o_level), 32'd1);
    check("simul_dac",  32'(o_dac_sample), 32'd129);
    check("simul_nour", 32'(o_underrun_cnt), 32'd0);
    check("simul_run",  32'(o_running), 32'd1);

    // Underrun: last sample out, then an empty tick.
    tick();
    check("ur_last_dac", 32'(o_dac_sample), 32'd200);
    check("ur_last_lvl", 32'(o_level), 32'd0);
    tick();
    check("ur_cnt",     32'(o_underrun_cnt), ONE_IF_STATS);
    check("ur_running", 32'(o_running), 32'd0);
    check("ur_dac_hold", 32'(o_dac_sample), 32'd200);
    check("ur_no_beat", 32'(aso_valid), 32'd0);

    // Re-prime with stream test values at the head.
    push(24'h000010);
    push(24'h000020);
    push(24'h800001);
    for (int v = 0; v < 61; v++) push(24'(32'h100 + v));
    step();
    check("reprime_run", 32'(o_running), 32'd1);

    // Backpressure: second pop overwrites the unaccepted beat.
    aso_ready = 1'b0;
    tick();
    check("bp_data1", aso_data, 32'h00000010);
    check("bp_vld1",  32'(aso_valid), 32'd1);
    tick();
    check("bp_data2", aso_data, 32'h00000020);
    check("bp_vld2",  32'(aso_valid), 32'd1);
    check("bp_drop",  32'(o_st_drop_cnt), ONE_IF_STATS);
    step();
    check("bp_hold_vld", 32'(aso_valid), 32'd1);
    aso_ready = 1'b1;
    step();
    check("bp_release", 32'(aso_valid), 32'd0);

    // Sign extension of a negative sample.
    tick();
    check("sext_data", aso_data, 32'hFF800001);
    check("sext_dac",  32'(o_dac_sample), 32'h00800001);
    check("sext_lvl",  32'(o_level), 32'd61);

    // Asynchronous reset mid-operation, asserted between edges.
    #3 reset = 1'b1;
    #1;
    check("arst_level",   32'(o_level), 32'd0);
    check("arst_running", 32'(o_running), 32'd0);
    check("arst_valid",   32'(aso_valid), 32'd0);
    check("arst_dac",     32'(o_dac_sample), 32'd0);
    check("arst_cnts",    {o_underrun_cnt, o_st_drop_cnt}, 32'd0);
    #2 reset = 1'b0;
    step();
    check("post_rst_level", 32'(o_level), 32'd0);
    check("post_rst_gen",   32'(o_gen_en), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
